mem_port_arbiter: RTL

//  Shares the single data/instruction memory port between instruction fetch (IF) and the EXE load-store unit (LSU).
//  One outstanding transaction at a time. LSU has priority, bounded by an anti-starvation streak counter.

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (IF) and the load-store
//   unit (LSU). Only one transaction is outstanding at a time. The LSU has
//   priority, but after MAX_LSU_STREAK consecutive LSU wins with IF waiting, the
//   next contested arbitration goes to IF. LSU accesses that are misaligned, or
//   whose size is not one-hot, are answered locally with an error (FAULT state).
//   A memory that never answers is timed out after RSP_TIMEOUT response cycles.
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   if_req_i/if_adr_i     : fetch request (held until if_gnt_o)
//   if_gnt_o/if_rvalid_o  : fetch accept / response pulses
//   if_rdata_o/if_err_o   : fetch data / access fault, valid with if_rvalid_o
//   lsu_req_i..lsu_size_i : LSU request fields (held until lsu_gnt_o)
//   lsu_gnt_o/lsu_rvalid_o: LSU accept / response pulses
//   lsu_rdata_o/lsu_err_o : raw memory word / misaligned-or-timeout error
//   mem_*_o               : request to memory (word address, byte enables)
//   mem_gnt_i/mem_rvalid_i/mem_rdata_i : memory handshake and read data
module mem_port_arbiter #(
    parameter int XLEN           = 32,
    parameter int MAX_LSU_STREAK = 4,
    parameter int RSP_TIMEOUT    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_adr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    output logic            if_err_o,
    input  logic            lsu_req_i,
    input  logic [XLEN-1:0] lsu_adr_i,
    input  logic            lsu_we_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    input  logic [2:0]      lsu_size_i,
    output logic            lsu_gnt_o,
    output logic            lsu_rvalid_o,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic            lsu_err_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_adr_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_be_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);
    localparam int SW = $clog2(MAX_LSU_STREAK + 1);
    localparam int TW = $clog2(RSP_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP, FAULT} state_t;

    state_t          state;
    logic            if_req_q, lsu_req_q;
    logic            owner_lsu;
    logic [SW-1:0]   streak;
    logic [TW-1:0]   timeout;
    logic [XLEN-1:0] adr_q, wdata_q;
    logic            we_q;
    logic [3:0]      be_q;

    // Fetch addresses are word-aligned on the bus; the low bits are dropped.
    logic unused_if_adr_bits;
    assign unused_if_adr_bits = ^if_adr_i[1:0];

    // LSU access decode: lane enables, lane-replicated store data, alignment.
    logic            lsu_misaligned;
    logic [3:0]      lsu_be;
    logic [XLEN-1:0] lsu_wdata_rep;
    always_comb begin
        lsu_misaligned = 1'b0;
        lsu_be         = 4'b1111;
        lsu_wdata_rep  = lsu_wdata_i;
        case (lsu_size_i)
            3'b001: begin
                lsu_be        = 4'b0001 << lsu_adr_i[1:0];
                lsu_wdata_rep = XLEN'({4{lsu_wdata_i[7:0]}});
            end
            3'b010: begin
                lsu_misaligned = lsu_adr_i[0];
                lsu_be         = 4'b0011 << lsu_adr_i[1:0];
                lsu_wdata_rep  = XLEN'({2{lsu_wdata_i[15:0]}});
            end
            3'b100:  lsu_misaligned = |lsu_adr_i[1:0];
            default: lsu_misaligned = 1'b1;  // non-one-hot size
        endcase
    end

    // Arbitration on the registered request lines.
    logic win_lsu, win_if;
    assign win_lsu = lsu_req_q && (!if_req_q || streak != SW'(MAX_LSU_STREAK));
    assign win_if  = if_req_q && !win_lsu;

    logic gnt, rsp_data, rsp_timeout;
    assign gnt         = (state == REQ) && mem_gnt_i;
    assign rsp_data    = (state == RSP) && mem_rvalid_i;
    assign rsp_timeout = (state == RSP) && !mem_rvalid_i && (timeout == TW'(RSP_TIMEOUT - 1));

    assign if_gnt_o     = gnt && !owner_lsu;
    assign if_rvalid_o  = (rsp_data || rsp_timeout) && !owner_lsu;
    assign if_rdata_o   = (rsp_data && !owner_lsu) ? mem_rdata_i : '0;
    assign if_err_o     = rsp_timeout && !owner_lsu;

    assign lsu_gnt_o    = (gnt && owner_lsu) || (state == FAULT);
    assign lsu_rvalid_o = ((rsp_data || rsp_timeout) && owner_lsu) || (state == FAULT);
    assign lsu_rdata_o  = (rsp_data && owner_lsu) ? mem_rdata_i : '0;
    assign lsu_err_o    = (rsp_timeout && owner_lsu) || (state == FAULT);

    // Memory fields are only driven while the request is presented.
    assign mem_req_o    = (state == REQ);
    assign mem_adr_o    = mem_req_o ? adr_q   : '0;
    assign mem_we_o     = mem_req_o && we_q;
    assign mem_wdata_o  = mem_req_o ? wdata_q : '0;
    assign mem_be_o     = mem_req_o ? be_q    : 4'b0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            if_req_q  <= 1'b0;
            lsu_req_q <= 1'b0;
            owner_lsu <= 1'b0;
            streak    <= '0;
            timeout   <= '0;
            adr_q     <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
        end else begin
            // A request granted this cycle is consumed, so the still-held
            // request line must not trigger a second arbitration.
            if_req_q  <= if_req_i && !if_gnt_o;
            lsu_req_q <= lsu_req_i && !lsu_gnt_o;
            case (state)
                IDLE: begin
                    if (win_lsu) begin
                        owner_lsu <= 1'b1;
                        adr_q     <= {lsu_adr_i[XLEN-1:2], 2'b00};
                        we_q      <= lsu_we_i;
                        wdata_q   <= lsu_wdata_rep;
                        be_q      <= lsu_we_i ? lsu_be : 4'b1111;
                        if (!if_req_i)
                            streak <= '0;
                        else if (streak != SW'(MAX_LSU_STREAK))
                            streak <= streak + 1'b1;
                        state     <= lsu_misaligned ? FAULT : REQ;
                    end else if (win_if) begin
                        owner_lsu <= 1'b0;
                        adr_q     <= {if_adr_i[XLEN-1:2], 2'b00};
                        we_q      <= 1'b0;
                        wdata_q   <= '0;
                        be_q      <= 4'b1111;
                        streak    <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        timeout <= '0;
                        state   <= RSP;
                    end
                end
                RSP: begin
                    if (mem_rvalid_i || rsp_timeout)
                        state <= IDLE;
                    else
                        timeout <= timeout + 1'b1;
                end
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Requesters must hold their request until it is granted.
    if_req_hold_a: assert property (@(posedge clk) disable iff (reset)
        (if_req_i && !if_gnt_o) |=> if_req_i);
    lsu_req_hold_a: assert property (@(posedge clk) disable iff (reset)
        (lsu_req_i && !lsu_gnt_o) |=> lsu_req_i);

endmodule
